// File: rtl/mux_tree_pkg.sv
// Shared types and sizing helpers for the pipelined mux tree.
// The token travels beside the data through every tree level.
package mux_tree_pkg;

    // Wide enough for the largest supported tree (256 channels).
    localparam int MAX_SELW = 8;

    typedef struct packed {
        logic                valid;
        logic [MAX_SELW-1:0] sel;
        logic                err;
    } token_t;

    function automatic int clog4(input int n);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        for (int i = 0; i < MAX_SELW; i++) begin
            if (span < n) begin
                span = span * 4;
                lv++;
            end
        end
        return lv;
    endfunction

    function automatic int padded_channels(input int n);
        return 1 << (2 * clog4(n));
    endfunction

endpackage

// File: rtl/mux4_stage.sv
// One tree level: GROUPS registered 4:1 muxes sharing one select digit.
// Data and token update only when a valid token passes, so outputs hold.
module mux4_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int GROUPS = 1,
    parameter int LEVEL  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*GROUPS*WIDTH-1:0] src,
    input  token_t                    src_tok,
    output logic [GROUPS*WIDTH-1:0]   q,
    output token_t                    q_tok
);

    logic [1:0]              digit;
    logic [GROUPS*WIDTH-1:0] pick;

    assign digit = src_tok.sel[2*LEVEL +: 2];

    always_comb begin
        pick = '0;
        for (int g = 0; g < GROUPS; g++) begin
            unique case (digit)
                2'd0: pick[g*WIDTH +: WIDTH] = src[(4*g+0)*WIDTH +: WIDTH];
                2'd1: pick[g*WIDTH +: WIDTH] = src[(4*g+1)*WIDTH +: WIDTH];
                2'd2: pick[g*WIDTH +: WIDTH] = src[(4*g+2)*WIDTH +: WIDTH];
                2'd3: pick[g*WIDTH +: WIDTH] = src[(4*g+3)*WIDTH +: WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            q_tok <= '0;
        end else if (src_tok.valid) begin
            q     <= pick;
            q_tok <= src_tok;
        end else begin
            q_tok.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_tree_pipelined.sv
// Pipelined N-to-1 mux: one registered 4:1 level per pipeline stage,
// with an optional wrapping scan counter driving the select.
module mux_tree_pipelined
    import mux_tree_pkg::*;
#(
    parameter int  WIDTH    = 1,
    parameter int  CHANNELS = 16,
    localparam int SELW     = $clog2(CHANNELS),
    localparam int LEVELS   = clog4(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      in_valid,
    input  logic                      scan_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      out_valid,
    output logic [SELW-1:0]           out_sel,
    output logic                      sel_err
);

    localparam int PADDED = padded_channels(CHANNELS);

    logic [SELW-1:0]         scan_cnt;
    logic [SELW-1:0]         eff_sel;
    logic                    range_err;
    logic [PADDED*WIDTH-1:0] din_pad;
    token_t                  launch_tok;
    token_t                  last_tok;
    logic                    unused_sel;

    assign eff_sel   = scan_en ? scan_cnt : sel;
    assign range_err = {1'b0, eff_sel} >= (SELW+1)'(CHANNELS);

    // Out-of-range selects always land on these zero pads, giving dout=0.
    assign din_pad = (PADDED*WIDTH)'(din);

    always_comb begin
        launch_tok       = '0;
        launch_tok.valid = in_valid;
        launch_tok.sel   = MAX_SELW'(eff_sel);
        launch_tok.err   = range_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (in_valid && scan_en) begin
            if (scan_cnt == SELW'(CHANNELS - 1))
                scan_cnt <= '0;
            else
                scan_cnt <= scan_cnt + 1'b1;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : lv
        localparam int GROUPS = PADDED >> (2 * (l + 1));
        logic [GROUPS*WIDTH-1:0] q;
        token_t                  tq;
        if (l == 0) begin : g_first
            mux4_stage #(
                .WIDTH  (WIDTH),
                .GROUPS (GROUPS),
                .LEVEL  (l)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .src     (din_pad),
                .src_tok (launch_tok),
                .q       (q),
                .q_tok   (tq)
            );
        end else begin : g_next
            mux4_stage #(
                .WIDTH  (WIDTH),
                .GROUPS (GROUPS),
                .LEVEL  (l)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .src     (lv[l-1].q),
                .src_tok (lv[l-1].tq),
                .q       (q),
                .q_tok   (tq)
            );
        end
    end

    assign last_tok   = lv[LEVELS-1].tq;
    assign dout       = lv[LEVELS-1].q;
    assign out_valid  = last_tok.valid;
    assign out_sel    = last_tok.sel[SELW-1:0];
    assign sel_err    = last_tok.err;
    assign unused_sel = ^{1'b0, last_tok.sel};

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Bench for mux_tree_pipelined: three configurations share one stimulus
// stream and are checked each cycle against a delay-line channel model.
module tb_mux_tree_pipelined;

    localparam int LAT  [3] = '{2, 2, 1};
    localparam int CHN  [3] = '{16, 10, 4};
    localparam int SW   [3] = '{4, 4, 2};
    localparam int WID  [3] = '{8, 4, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       scan_en = 1'b0;
    logic [7:0] sel = '0;

    logic [7:0] ch [3][16];

    logic [127:0] din_a;
    logic [39:0]  din_b;
    logic [7:0]   din_c;

    logic [7:0] dout_a;
    logic [3:0] dout_b;
    logic [1:0] dout_c;
    logic [3:0] out_sel_a, out_sel_b;
    logic [1:0] out_sel_c;
    logic       out_valid_a, out_valid_b, out_valid_c;
    logic       sel_err_a, sel_err_b, sel_err_c;

    int n_vec = 0;
    int n_bad = 0;

    // model state: per-DUT delay line plus held output values
    logic       pv [3][2];
    logic [7:0] pd [3][2];
    logic [7:0] ps [3][2];
    logic       pe [3][2];
    logic [7:0] hd [3];
    logic [7:0] hs [3];
    logic       he [3];
    int         scan [3];

    always #5 clk = ~clk;

    always_comb begin
        din_a = '0;
        din_b = '0;
        din_c = '0;
        for (int k = 0; k < 16; k++) din_a[k*8 +: 8] = ch[0][k];
        for (int k = 0; k < 10; k++) din_b[k*4 +: 4] = ch[1][k][3:0];
        for (int k = 0; k < 4; k++)  din_c[k*2 +: 2] = ch[2][k][1:0];
    end

    mux_tree_pipelined #(.WIDTH(8), .CHANNELS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel[3:0]),
        .in_valid(in_valid), .scan_en(scan_en), .dout(dout_a),
        .out_valid(out_valid_a), .out_sel(out_sel_a), .sel_err(sel_err_a)
    );

    mux_tree_pipelined #(.WIDTH(4), .CHANNELS(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel[3:0]),
        .in_valid(in_valid), .scan_en(scan_en), .dout(dout_b),
        .out_valid(out_valid_b), .out_sel(out_sel_b), .sel_err(sel_err_b)
    );

    mux_tree_pipelined #(.WIDTH(2), .CHANNELS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .sel(sel[1:0]),
        .in_valid(in_valid), .scan_en(scan_en), .dout(dout_c),
        .out_valid(out_valid_c), .out_sel(out_sel_c), .sel_err(sel_err_c)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                scan[d] = 0;
                hd[d] = '0;
                hs[d] = '0;
                he[d] = 1'b0;
                for (int k = 0; k < 2; k++) pv[d][k] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                int eff;
                eff = scan_en ? scan[d] : (int'(sel) & ((1 << SW[d]) - 1));
                for (int k = LAT[d] - 1; k > 0; k--) begin
                    pv[d][k] = pv[d][k-1];
                    pd[d][k] = pd[d][k-1];
                    ps[d][k] = ps[d][k-1];
                    pe[d][k] = pe[d][k-1];
                end
                pv[d][0] = in_valid;
                ps[d][0] = 8'(eff);
                pe[d][0] = (eff >= CHN[d]);
                pd[d][0] = (eff < CHN[d]) ? ch[d][eff] : 8'h00;
                if (in_valid && scan_en) scan[d] = (scan[d] + 1) % CHN[d];
                if (pv[d][LAT[d]-1]) begin
                    hd[d] = pd[d][LAT[d]-1];
                    hs[d] = ps[d][LAT[d]-1];
                    he[d] = pe[d][LAT[d]-1];
                end
            end
        end
    end

    task automatic check(input int d, input logic v, input logic [7:0] dd,
                         input logic [7:0] ss, input logic e);
        n_vec++;
        if (v !== pv[d][LAT[d]-1] || dd !== hd[d] || ss !== hs[d] || e !== he[d]) begin
            n_bad++;
            $display("FAIL model dut%0d t=%0t got v=%b d=%h s=%0d e=%b want v=%b d=%h s=%0d e=%b",
                     d, $time, v, dd, ss, e, pv[d][LAT[d]-1], hd[d], hs[d], he[d]);
        end
    endtask

    always @(negedge clk) begin
        check(0, out_valid_a, dout_a, 8'(out_sel_a), sel_err_a);
        check(1, out_valid_b, 8'(dout_b), 8'(out_sel_b), sel_err_b);
        check(2, out_valid_c, 8'(dout_c), 8'(out_sel_c), sel_err_c);
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic sc);
        in_valid = v;
        sel = s;
        scan_en = sc;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_ch();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 16; k++) ch[d][k] = 8'h00;
    endtask

    task automatic rand_ch();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 16; k++)
                ch[d][k] = 8'($urandom_range(0, (1 << WID[d]) - 1));
    endtask

    initial begin
        clear_ch();
        #1 rst_n = 1'b0;

        // launches under reset are ignored
        rand_ch();
        step(1'b1, 8'd5, 1'b0);
        step(1'b1, 8'd9, 1'b1);
        step(1'b1, 8'd2, 1'b0);
        lit("rst_valid_a", 8'(out_valid_a), 8'h00);
        lit("rst_dout_a", dout_a, 8'h00);
        lit("rst_valid_c", 8'(out_valid_c), 8'h00);

        // first launch latency: 2 for 16 channels, 1 for 4 channels
        rst_n = 1'b1;
        ch[0][3] = 8'h5A;
        step(1'b1, 8'd3, 1'b0);
        lit("lat1_valid_a", 8'(out_valid_a), 8'h00);
        lit("lat1_valid_c", 8'(out_valid_c), 8'h01);
        step(1'b0, 8'd0, 1'b0);
        lit("lat2_valid_a", 8'(out_valid_a), 8'h01);
        lit("lat2_dout_a", dout_a, 8'h5A);
        lit("lat2_sel_a", 8'(out_sel_a), 8'h03);

        // single-bit propagation through the whole tree
        clear_ch();
        ch[0][0] = 8'h01;
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        lit("prop0_dout", dout_a, 8'h01);
        lit("prop0_sel", 8'(out_sel_a), 8'h00);
        ch[0][0] = 8'h00;
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        lit("prop0_zero", dout_a, 8'h00);
        ch[0][15] = 8'h01;
        step(1'b1, 8'd15, 1'b0);
        ch[0][15] = 8'h00;
        step(1'b0, 8'd0, 1'b0);
        lit("prop15_sampled", dout_a, 8'h01);
        lit("prop15_sel", 8'(out_sel_a), 8'h0F);
        ch[0][15] = 8'h01;
        step(1'b1, 8'd3, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        lit("prop3_dout", dout_a, 8'h00);

        // back-to-back sweep with one bubble
        for (int k = 0; k < 16; k++) begin
            ch[0][k] = 8'(k + 8'h10);
            ch[1][k] = 8'((k * 3 + 1) & 4'hF);
            ch[2][k] = 8'((k + 1) & 2'h3);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 5) step(1'b0, 8'd0, 1'b0);
            step(1'b1, 8'(i), 1'b0);
        end
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);

        // scan mode, a manual interlude, then resume
        for (int i = 0; i < 20; i++) step(1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd7, 1'b0);
        step(1'b1, 8'd0, 1'b1);
        lit("scan_manual_sel", 8'(out_sel_a), 8'h07);
        step(1'b0, 8'd0, 1'b0);
        lit("scan_resume_a", 8'(out_sel_a), 8'h04);
        lit("scan_resume_b", 8'(out_sel_b), 8'h00);
        lit("scan_resume_c", 8'(out_sel_c), 8'h00);

        // non-power-of-4 channel count and range error
        step(1'b1, 8'd9, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        lit("b_sel9_dout", 8'(dout_b), 8'h0C);
        lit("b_sel9_err", 8'(sel_err_b), 8'h00);
        step(1'b1, 8'd12, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        lit("b_sel12_err", 8'(sel_err_b), 8'h01);
        lit("b_sel12_dout", 8'(dout_b), 8'h00);
        lit("a_sel12_dout", dout_a, 8'h1C);

        // reset pulse between edges with tokens in flight
        step(1'b1, 8'd0, 1'b1);
        step(1'b1, 8'd0, 1'b1);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        lit("midrst_valid_a", 8'(out_valid_a), 8'h00);
        step(1'b0, 8'd0, 1'b0);
        lit("midrst_valid_a2", 8'(out_valid_a), 8'h00);
        step(1'b1, 8'd5, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        lit("midrst_scan_sel", 8'(out_sel_a), 8'h00);
        lit("midrst_dout", dout_a, 8'h10);

        // mixed traffic checked by the model alone
        for (int i = 0; i < 40; i++) begin
            rand_ch();
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
